// File: rtl/pulse_tx_queue.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_tx_queue
//  Description : Fast-domain source side of a multi-channel toggle/ack pulse
//                synchronizer. Queues single-cycle pulses per channel in a
//                saturating counter and sends them one at a time as request
//                toggles, waiting for the synchronized ack toggle between.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_tx_queue #(
    parameter int NCH         = 4,
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NCH-1:0]       pulse_in,
    input  logic [NCH-1:0]       ack_tgl,
    input  logic [NCH-1:0]       ovf_clr,
    output logic [NCH-1:0]       req_tgl,
    output logic [NCH*CNT_W-1:0] pending,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       ovf
);

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_WAIT_ACK = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    // Every channel is an independent copy; no arbitration between them.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] ack_sync_q;
        logic                   w_ack_s;
        state_e                 state_q, state_d;
        logic                   req_q, req_d;
        logic [CNT_W-1:0]       pend_q, pend_d;
        logic                   ovf_q, ovf_d;
        logic                   w_done;
        logic                   w_accept;

        // Ack toggle synchronizer; only its last stage is ever looked at.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                ack_sync_q <= '0;
            end else begin
                ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_tgl[g]};
            end
        end

        assign w_ack_s  = ack_sync_q[SYNC_STAGES-1];

        // A completion is the synchronized ack catching up with our request.
        // The last stage shows an ack toggle after edge m+SYNC_STAGES-1 and
        // the FSM acts on it at the following edge.
        assign w_done   = (state_q == S_WAIT_ACK) && (w_ack_s == req_q);

        // A pulse at saturation is still taken if a completion frees a slot.
        assign w_accept = pulse_in[g] && ((pend_q != c_cnt_max) || w_done);

        // Pending counter and sticky overflow; a new drop beats a clear.
        always_comb begin
            pend_d = pend_q;
            ovf_d  = ovf_q;
            if (w_accept && !w_done) begin
                pend_d = pend_q + c_cnt_one;
            end else if (w_done && !w_accept) begin
                pend_d = pend_q - c_cnt_one;
            end
            if (pulse_in[g] && !w_accept) begin
                ovf_d = 1'b1;
            end else if (ovf_clr[g]) begin
                ovf_d = 1'b0;
            end
        end

        // Request FSM: launch one toggle per queued pulse, then wait for ack.
        always_comb begin
            state_d = state_q;
            req_d   = req_q;
            case (state_q)
                S_IDLE: begin
                    if (pend_q != '0) begin
                        req_d   = ~req_q;
                        state_d = S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (w_done) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Channel state registers; reset drops everything queued or in flight.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                state_q <= S_IDLE;
                req_q   <= 1'b0;
                pend_q  <= '0;
                ovf_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                req_q   <= req_d;
                pend_q  <= pend_d;
                ovf_q   <= ovf_d;
            end
        end

        assign req_tgl[g]                  = req_q;
        assign busy[g]                     = (state_q == S_WAIT_ACK);
        assign ovf[g]                      = ovf_q;
        assign pending[g*CNT_W +: CNT_W]   = pend_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_pulse_tx_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pulse_tx_queue
//  Description : Self-checking bench for pulse_tx_queue. A CNT_W=4 instance
//                covers single pulse, burst, simultaneous events, channel
//                independence and reset; a CNT_W=2 instance is driven from a
//                vector table for saturation, overflow and ack latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_tx_queue;

    logic        clk   = 1'b0;
    logic        clk_s = 1'b0;
    logic        rstn  = 1'b0;

    // Main instance (CNT_W=4)
    logic [3:0]  pulse_in = '0;
    logic [3:0]  ovf_clr  = '0;
    logic [3:0]  man_ack  = '0;
    logic        echo_en  = 1'b0;
    logic [3:0]  ack_tgl;
    logic [3:0]  req_tgl;
    logic [15:0] pending;
    logic [3:0]  busy;
    logic [3:0]  ovf;

    // Saturation instance (CNT_W=2)
    logic [3:0]  s_pulse = '0;
    logic [3:0]  s_ack   = '0;
    logic [3:0]  s_clr   = '0;
    logic [3:0]  s_req;
    logic [7:0]  s_pend;
    logic [3:0]  s_busy;
    logic [3:0]  s_ovf;

    // Slow-domain receiver model: echoes req as ack after 3 slow cycles
    logic [3:0]  echo1, echo2, echo3;

    int checks = 0;
    int errors = 0;

    pulse_tx_queue #(.NCH(4), .CNT_W(4), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .pulse_in (pulse_in),
        .ack_tgl  (ack_tgl),
        .ovf_clr  (ovf_clr),
        .req_tgl  (req_tgl),
        .pending  (pending),
        .busy     (busy),
        .ovf      (ovf)
    );

    pulse_tx_queue #(.NCH(4), .CNT_W(2), .SYNC_STAGES(2)) dut_sat (
        .clk      (clk),
        .rstn     (rstn),
        .pulse_in (s_pulse),
        .ack_tgl  (s_ack),
        .ovf_clr  (s_clr),
        .req_tgl  (s_req),
        .pending  (s_pend),
        .busy     (s_busy),
        .ovf      (s_ovf)
    );

    initial forever #5 clk = ~clk;
    initial begin
        #3;
        forever #20 clk_s = ~clk_s;
    end

    always @(posedge clk_s or negedge rstn) begin
        if (!rstn) begin
            echo1 <= '0;
            echo2 <= '0;
            echo3 <= '0;
        end else begin
            echo1 <= req_tgl;
            echo2 <= echo1;
            echo3 <= echo2;
        end
    end

    assign ack_tgl = echo_en ? echo3 : man_ack;

    // Count request toggles per channel of the main instance
    logic [3:0] req_prev = '0;
    int         tog_cnt [4] = '{0, 0, 0, 0};
    int         tog_base[4];

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (req_tgl[i] != req_prev[i]) tog_cnt[i] <= tog_cnt[i] + 1;
        end
        req_prev <= req_tgl;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    typedef struct {
        logic [3:0] pulse;
        logic [3:0] ack;
        logic [3:0] clr;
        logic [1:0] pend0;
        logic       busy0;
        logic       ovf0;
        logic       req0;
    } vec_t;

    vec_t tbl[15];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 4; i++) tog_base[i] = tog_cnt[i];
    endtask

    task automatic do_reset(input logic echo);
        pulse_in = '0;
        ovf_clr  = '0;
        man_ack  = '0;
        s_pulse  = '0;
        s_ack    = '0;
        s_clr    = '0;
        rstn     = 1'b0;
        echo_en  = echo;
        repeat (2) step();
        rstn = 1'b1;
        repeat (2) step();
        snap();
    endtask

    initial begin
        int  peak;
        bit  found;
        bit  done;

        //            pulse  ack    clr    pend0 busy0 ovf0  req0
        tbl[0]  = '{4'h1, 4'h0, 4'h0, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{4'h1, 4'h0, 4'h0, 2'd2, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{4'h1, 4'h0, 4'h0, 2'd3, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{4'h1, 4'h0, 4'h0, 2'd3, 1'b1, 1'b1, 1'b1};
        tbl[4]  = '{4'h1, 4'h0, 4'h1, 2'd3, 1'b1, 1'b1, 1'b1};
        tbl[5]  = '{4'h0, 4'h0, 4'h1, 2'd3, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{4'h0, 4'h1, 4'h0, 2'd3, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{4'h0, 4'h1, 4'h0, 2'd3, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{4'h1, 4'h1, 4'h0, 2'd3, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{4'h0, 4'h1, 4'h0, 2'd3, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{4'h0, 4'h1, 4'h0, 2'd3, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{4'h0, 4'h0, 4'h0, 2'd3, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{4'h0, 4'h0, 4'h0, 2'd3, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{4'h0, 4'h0, 4'h0, 2'd2, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{4'h0, 4'h0, 4'h0, 2'd2, 1'b1, 1'b0, 1'b1};

        // Reset state of both instances
        do_reset(1'b0);
        check("rst_req",    32'(req_tgl), 32'h0);
        check("rst_pend",   32'(pending), 32'h0);
        check("rst_busy",   32'(busy),    32'h0);
        check("rst_ovf",    32'(ovf),     32'h0);
        check("rst_s_pend", 32'(s_pend),  32'h0);
        check("rst_s_req",  32'(s_req),   32'h0);

        // T3 + ack latency + max-with-completion: table on CNT_W=2 instance
        for (int v = 0; v < 15; v++) begin
            s_pulse = tbl[v].pulse;
            s_ack   = tbl[v].ack;
            s_clr   = tbl[v].clr;
            step();
            check($sformatf("tbl%0d_pend", v), 32'(s_pend), 32'({6'b0, tbl[v].pend0}));
            check($sformatf("tbl%0d_busy", v), 32'(s_busy), 32'({3'b0, tbl[v].busy0}));
            check($sformatf("tbl%0d_ovf",  v), 32'(s_ovf),  32'({3'b0, tbl[v].ovf0}));
            check($sformatf("tbl%0d_req",  v), 32'(s_req),  32'({3'b0, tbl[v].req0}));
        end

        // T1: single pulse on ch0 with echoing receiver
        do_reset(1'b1);
        pulse_in = 4'b0001;
        step();
        check("t1_pend_k",  32'(pending[3:0]), 32'd1);
        check("t1_req_k",   32'(req_tgl[0]),   32'd0);
        pulse_in = 4'b0000;
        step();
        check("t1_req_k1",  32'(req_tgl[0]),   32'd1);
        check("t1_busy_k1", 32'(busy[0]),      32'd1);
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            step();
            if (ack_tgl[0]) found = 1'b1;
        end
        check("t1_ack_seen", 32'(found), 32'd1);
        check("t1_busy_m",   32'(busy[0]), 32'd1);
        step();
        check("t1_busy_m1",  32'(busy[0]), 32'd1);
        step();
        check("t1_busy_m2",  32'(busy[0]),      32'd0);
        check("t1_pend_m2",  32'(pending[3:0]), 32'd0);
        repeat (20) step();
        check("t1_toggles",  32'(tog_cnt[0] - tog_base[0]), 32'd1);
        check("t1_req_end",  32'(req_tgl),                  32'h1);

        // T2: burst of 7 pulses on ch1
        do_reset(1'b1);
        peak = 0;
        pulse_in = 4'b0010;
        repeat (7) begin
            step();
            if (int'(pending[7:4]) > peak) peak = int'(pending[7:4]);
        end
        check("t2_pend7", 32'(pending[7:4]), 32'd7);
        pulse_in = 4'b0000;
        done = 1'b0;
        for (int n = 0; n < 2000 && !done; n++) begin
            step();
            if (int'(pending[7:4]) > peak) peak = int'(pending[7:4]);
            if (pending[7:4] == 4'd0 && !busy[1]) done = 1'b1;
        end
        check("t2_drained", 32'(done), 32'd1);
        repeat (3) step();
        check("t2_peak",    32'(peak),                      32'd7);
        check("t2_toggles", 32'(tog_cnt[1] - tog_base[1]), 32'd7);
        check("t2_ovf",     32'(ovf[1]),                    32'd0);
        check("t2_req",     32'(req_tgl[1]),                32'd1);

        // T4: pulse coincident with a completion at pending=2 (ch2)
        do_reset(1'b0);
        pulse_in = 4'b0100;
        step();
        check("t4_pend1", 32'(pending[11:8]), 32'd1);
        step();
        check("t4_pend2", 32'(pending[11:8]), 32'd2);
        check("t4_req1",  32'(req_tgl[2]),    32'd1);
        pulse_in = 4'b0000;
        man_ack  = 4'b0100;
        step();
        step();
        check("t4_busy_wait", 32'(busy[2]), 32'd1);
        pulse_in = 4'b0100;
        step();
        check("t4_pend_same", 32'(pending[11:8]), 32'd2);
        check("t4_busy_idle", 32'(busy[2]),       32'd0);
        pulse_in = 4'b0000;
        step();
        check("t4_req_again", 32'(req_tgl[2]),    32'd0);
        check("t4_busy_again",32'(busy[2]),       32'd1);
        check("t4_pend_again",32'(pending[11:8]), 32'd2);

        // T5: ch0 and ch3 together, acked at different times
        do_reset(1'b0);
        pulse_in = 4'b1001;
        step();
        check("t5_pend", 32'(pending), 32'h1001);
        pulse_in = 4'b0000;
        step();
        check("t5_req",  32'(req_tgl), 32'h9);
        check("t5_busy", 32'(busy),    32'h9);
        man_ack = 4'b0001;
        repeat (3) step();
        check("t5_busy_ch0done", 32'(busy),    32'h8);
        check("t5_pend_ch0done", 32'(pending), 32'h1000);
        repeat (4) step();
        check("t5_busy_ch3wait", 32'(busy),    32'h8);
        man_ack = 4'b1001;
        repeat (3) step();
        check("t5_busy_all",     32'(busy),    32'h0);
        check("t5_pend_all",     32'(pending), 32'h0);
        repeat (5) step();
        check("t5_req_end",      32'(req_tgl), 32'h9);
        check("t5_tog0", 32'(tog_cnt[0] - tog_base[0]), 32'd1);
        check("t5_tog1", 32'(tog_cnt[1] - tog_base[1]), 32'd0);
        check("t5_tog2", 32'(tog_cnt[2] - tog_base[2]), 32'd0);
        check("t5_tog3", 32'(tog_cnt[3] - tog_base[3]), 32'd1);

        // T6: asynchronous reset while busy with pending=4 on ch1
        do_reset(1'b0);
        pulse_in = 4'b0010;
        repeat (4) step();
        pulse_in = 4'b0000;
        check("t6_pend4", 32'(pending[7:4]), 32'd4);
        check("t6_busy",  32'(busy[1]),      32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("t6_async_req",  32'(req_tgl), 32'h0);
        check("t6_async_pend", 32'(pending), 32'h0);
        check("t6_async_busy", 32'(busy),    32'h0);
        check("t6_async_ovf",  32'(ovf),     32'h0);
        repeat (2) step();
        rstn = 1'b1;
        step();
        snap();
        repeat (10) step();
        check("t6_no_toggle", 32'(tog_cnt[1] - tog_base[1]), 32'd0);
        check("t6_req_post",  32'(req_tgl), 32'h0);
        check("t6_pend_post", 32'(pending), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
